// File: rtl/serial_adder_if.sv
// Operand/result handshake bundle for the bit-serial adder.
// master: upstream/downstream side (drives operands, consumes result).
// slave:  the adder itself.
interface serial_adder_if #(
  parameter int unsigned WIDTH = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout
  );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial ripple adder: a + b + cin, one full-adder cell plus a carry flop,
// one bit per clock, LSB first. Valid/ready handshake on input and output.
// The result is held on sum/cout until the next result is produced.
module serial_adder #(
  parameter int unsigned WIDTH = 4
) (
  input  logic           clk,
  input  logic           rst,   // asynchronous, active-low
  serial_adder_if.slave  bus
);

  localparam int unsigned CW = ($clog2(WIDTH) > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    ADD,
    DONE
  } state_t;

  state_t           state;
  state_t           state_nxt;

  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  // Partial sum keeps only the upper WIDTH-1 bits: the bit that would shift
  // out of position 0 is never needed, since the final sum is taken from the
  // combinational next value on the last ADD cycle.
  logic [WIDTH-1:1] sum_sr;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic             s_bit;
  logic             c_nxt;
  logic [WIDTH-1:0] sum_nxt;
  logic             last;
  logic             in_fire;
  logic             out_fire;

  // Full-adder cell, shift-in value, and handshake/terminal-count decode.
  always_comb begin
    s_bit    = a_sr[0] ^ b_sr[0] ^ carry;
    c_nxt    = (a_sr[0] & b_sr[0]) | (a_sr[0] & carry) | (b_sr[0] & carry);
    sum_nxt  = {s_bit, sum_sr};
    last     = (cnt == CW'(WIDTH - 1));
    in_fire  = (state == IDLE) && bus.in_valid;
    out_fire = (state == DONE) && bus.out_ready;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_fire)  state_nxt = ADD;
      ADD:     if (last)     state_nxt = DONE;
      DONE:    if (out_fire) state_nxt = IDLE;
      default:               state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Operand load, serial shift datapath and result capture.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_sr   <= '0;
      b_sr   <= '0;
      sum_sr <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      carry  <= 1'b0;
      cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_fire) begin
            a_sr  <= bus.a;
            b_sr  <= bus.b;
            carry <= bus.cin;
            cnt   <= '0;
          end
        end
        ADD: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          carry  <= c_nxt;
          sum_sr <= sum_nxt[WIDTH-1:1];
          cnt    <= cnt + 1'b1;
          if (last) begin
            sum_q  <= sum_nxt;
            cout_q <= c_nxt;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed scenarios on a 4-bit
// instance, random operands with output stalls on an 8-bit instance.
// Expected results are plain integer a + b + cin.
module tb_serial_adder;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  serial_adder_if #(.WIDTH(4)) bus4 ();
  serial_adder_if #(.WIDTH(8)) bus8 ();

  serial_adder #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
  serial_adder #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));

  int passed = 0;
  int total  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- 4-bit instance helpers ----------------
  task automatic issue4(input int a, input int b, input int cin);
    logic [3:0] av, bv;
    av = a[3:0];
    bv = b[3:0];
    bus4.a        = av;
    bus4.b        = bv;
    bus4.cin      = cin[0];
    bus4.in_valid = 1'b1;
    check("in_ready_before_issue", 32'(bus4.in_ready), 32'd1);
    tick();
    bus4.in_valid = 1'b0;
    bus4.a        = 4'($urandom);
    bus4.b        = 4'($urandom);
    bus4.cin      = 1'($urandom);
  endtask

  task automatic wait_done4(input string tag, input int expv);
    int k;
    k = 0;
    while (!bus4.out_valid && k < 20) begin
      tick();
      k++;
    end
    check({tag, "_latency"}, 32'(k), 32'd4);
    check({tag, "_result"}, 32'({bus4.cout, bus4.sum}), 32'(expv));
  endtask

  task automatic ack4(input string tag, input int expv);
    bus4.out_ready = 1'b1;
    tick();
    bus4.out_ready = 1'b0;
    check({tag, "_ov_drop"}, 32'(bus4.out_valid), 32'd0);
    check({tag, "_ir_back"}, 32'(bus4.in_ready), 32'd1);
    check({tag, "_held"}, 32'({bus4.cout, bus4.sum}), 32'(expv));
  endtask

  task automatic op4(input string tag, input int a, input int b, input int cin);
    issue4(a, b, cin);
    wait_done4(tag, a + b + cin);
    ack4(tag, a + b + cin);
  endtask

  initial begin
    int exp_q[$];
    int last_acc, results, accepts, prev_ov, e;
    int a, b, c, k, stall;

    bus4.in_valid = 1'b0; bus4.a = '0; bus4.b = '0; bus4.cin = 1'b0; bus4.out_ready = 1'b0;
    bus8.in_valid = 1'b0; bus8.a = '0; bus8.b = '0; bus8.cin = 1'b0; bus8.out_ready = 1'b0;

    // Reset state
    tick();
    tick();
    check("rst_in_ready",  32'(bus4.in_ready),  32'd1);
    check("rst_out_valid", 32'(bus4.out_valid), 32'd0);
    check("rst_sum",       32'(bus4.sum),       32'd0);
    check("rst_cout",      32'(bus4.cout),      32'd0);
    #3 rst = 1'b1;
    tick();

    // 1-2: basic sums and overflow
    op4("t1_3p5", 3, 5, 0);
    op4("t2_Fp1", 15, 1, 0);
    op4("t2_FpFc", 15, 15, 1);

    // 3: output stall, operands presented during DONE must be dropped
    issue4(2, 3, 1);
    wait_done4("t3", 6);
    for (int i = 0; i < 6; i++) begin
      if (i == 2) begin
        bus4.a = 4'd1; bus4.b = 4'd1; bus4.cin = 1'b0; bus4.in_valid = 1'b1;
      end else begin
        bus4.in_valid = 1'b0;
      end
      tick();
      check("t3_ov_hold",  32'(bus4.out_valid), 32'd1);
      check("t3_ir_low",   32'(bus4.in_ready),  32'd0);
      check("t3_res_hold", 32'({bus4.cout, bus4.sum}), 32'd6);
    end
    bus4.in_valid = 1'b0;
    ack4("t3", 6);
    for (int i = 0; i < 8; i++) tick();
    check("t3_no_ghost_op", 32'(bus4.out_valid), 32'd0);
    check("t3_still_idle",  32'(bus4.in_ready),  32'd1);
    check("t3_kept_result", 32'({bus4.cout, bus4.sum}), 32'd6);

    // 4: reset during ADD aborts, clears outputs at once
    issue4(5, 6, 0);
    tick();
    #2 rst = 1'b0;
    #1;
    check("t4_rst_ov",  32'(bus4.out_valid), 32'd0);
    check("t4_rst_sum", 32'(bus4.sum),       32'd0);
    check("t4_rst_ir",  32'(bus4.in_ready),  32'd1);
    #2 rst = 1'b1;
    tick();
    op4("t4_7p2", 7, 2, 0);

    // 5: in_valid and out_ready tied high, back-to-back operation
    last_acc = -1; results = 0; accepts = 0; prev_ov = 0;
    bus4.out_ready = 1'b1;
    for (int cyc = 0; cyc < 72; cyc++) begin
      if (bus4.out_valid) begin
        check("t5_ov_width", 32'(prev_ov), 32'd0);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("t5_result", 32'({bus4.cout, bus4.sum}), 32'(e));
        end else begin
          check("t5_unexpected_result", 32'd1, 32'(exp_q.size()));
        end
        results++;
      end
      prev_ov = int'(bus4.out_valid);
      bus4.in_valid = (cyc < 60);
      a = $urandom_range(0, 15); b = $urandom_range(0, 15); c = $urandom_range(0, 1);
      bus4.a = a[3:0]; bus4.b = b[3:0]; bus4.cin = c[0];
      if (bus4.in_ready && bus4.in_valid) begin
        exp_q.push_back(a + b + c);
        if (last_acc >= 0) check("t5_interval", 32'(cyc - last_acc), 32'd6);
        last_acc = cyc;
        accepts++;
      end
      tick();
    end
    bus4.in_valid = 1'b0;
    bus4.out_ready = 1'b0;
    check("t5_accepts", 32'(accepts), 32'd10);
    check("t5_all_results", 32'(results), 32'(accepts));

    // 6: 8-bit instance, random operands, random output stalls
    for (int n = 0; n < 1000; n++) begin
      stall = $urandom_range(0, 2);
      for (int i = 0; i < stall; i++) tick();
      a = $urandom_range(0, 255); b = $urandom_range(0, 255); c = $urandom_range(0, 1);
      e = a + b + c;
      bus8.a = a[7:0]; bus8.b = b[7:0]; bus8.cin = c[0];
      bus8.in_valid = 1'b1;
      check("t6_in_ready", 32'(bus8.in_ready), 32'd1);
      tick();
      bus8.in_valid = 1'b0;
      bus8.a = 8'($urandom); bus8.b = 8'($urandom);
      k = 0;
      while (!bus8.out_valid && k < 40) begin
        tick();
        k++;
      end
      check("t6_latency", 32'(k), 32'd8);
      stall = $urandom_range(0, 3);
      for (int i = 0; i < stall; i++) tick();
      check("t6_result", 32'({bus8.cout, bus8.sum}), 32'(e));
      bus8.out_ready = 1'b1;
      tick();
      bus8.out_ready = 1'b0;
      check("t6_ov_drop", 32'(bus8.out_valid), 32'd0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
